// File: rtl/spi_pkg.sv
// Shared SPI slave types: bus mode encoding, FSM states and edge-role helpers.
package spi_pkg;

  // Encoded as {cpol, cpha}
  typedef enum logic [1:0] {
    Mode0 = 2'b00,
    Mode1 = 2'b01,
    Mode2 = 2'b10,
    Mode3 = 2'b11
  } spi_mode_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } spi_state_e;

  function automatic logic spi_sample_edge(spi_mode_e mode, logic rise, logic fall);
    logic [1:0] m;
    logic       lead;
    logic       trail;
    m     = mode;
    lead  = m[1] ? fall : rise;
    trail = m[1] ? rise : fall;
    return m[0] ? trail : lead;
  endfunction

  function automatic logic spi_shift_edge(spi_mode_e mode, logic rise, logic fall);
    logic [1:0] m;
    logic       lead;
    logic       trail;
    m     = mode;
    lead  = m[1] ? fall : rise;
    trail = m[1] ? rise : fall;
    return m[0] ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin with rise/fall detection.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  // Level and edges come from the same pair so data stays aligned with sck edges
  assign q_o    = sync_q[SYNC_STAGES-2];
  assign rise_o = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign fall_o = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_cfg.sv
// SPI slave with runtime-selectable mode and bit order, buffered TX/RX handshakes
// and underrun/overrun/abort status pulses.
module spi_slave_cfg
  import spi_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      SYNC_STAGES = 3,
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'('hFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic             sck,
  input  logic             mosi,
  input  logic             cs_n,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             tx_underrun,
  output logic             rx_overrun,
  output logic             frame_abort
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef logic [WIDTH-1:0] word_t;

  function automatic logic first_bit(word_t w, logic lsb);
    return lsb ? w[0] : w[WIDTH-1];
  endfunction

  function automatic word_t shift_out(word_t w, logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_s, cs_rise, cs_fall;
  logic unused_sync;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sck),
    .q_o   (sck_s),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (mosi),
    .q_o   (mosi_s),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  // Reset to 0 so a CS already low when reset releases never looks like a fresh fall
  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cs_n),
    .q_o   (cs_s),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall, cs_s};

  spi_state_e      state_q, state_d;
  spi_mode_e       mode_q, mode_d;
  logic            lsb_q, lsb_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  word_t           tx_shift_q, tx_shift_d;
  word_t           rx_shift_q, rx_shift_d;
  word_t           rx_data_q, rx_data_d;
  word_t           tx_hold_q, tx_hold_d;
  logic            miso_q, miso_d;
  logic            rx_valid_q, rx_valid_d;
  logic            tx_full_q, tx_full_d;
  logic            start_pend_q, start_pend_d;
  logic            underrun_q, underrun_d;
  logic            overrun_q, overrun_d;
  logic            abort_q, abort_d;

  logic            sample_edge, shift_edge;
  logic [1:0]      mode_bits;

  assign sample_edge = spi_sample_edge(mode_q, sck_rise, sck_fall);
  assign shift_edge  = spi_shift_edge(mode_q, sck_rise, sck_fall);
  assign mode_bits   = mode_q;

  always_comb begin
    logic      word_start;
    logic      tx_fill;
    spi_mode_e mode_now;
    logic [1:0] mode_now_bits;
    logic      lsb_now;
    word_t     load_word;
    word_t     rx_word;

    state_d      = state_q;
    mode_d       = mode_q;
    lsb_d        = lsb_q;
    bit_cnt_d    = bit_cnt_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    rx_data_d    = rx_data_q;
    tx_hold_d    = tx_hold_q;
    miso_d       = miso_q;
    rx_valid_d   = rx_valid_q;
    tx_full_d    = tx_full_q;
    start_pend_d = 1'b0;
    underrun_d   = 1'b0;
    overrun_d    = 1'b0;
    abort_d      = 1'b0;
    word_start   = 1'b0;
    mode_now     = mode_q;
    lsb_now      = lsb_q;
    load_word    = IDLE_WORD;
    rx_word      = lsb_q ? {mosi_s, rx_shift_q[WIDTH-1:1]} : {rx_shift_q[WIDTH-2:0], mosi_s};
    tx_fill      = tx_valid & ~tx_full_q;

    if (tx_fill) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StActive;
          mode_now   = spi_mode_e'({cpol, cpha});
          lsb_now    = lsb_first;
          mode_d     = mode_now;
          lsb_d      = lsb_now;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          word_start = 1'b1;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d   = StIdle;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          abort_d   = (bit_cnt_q != '0);
        end else if (start_pend_q) begin
          word_start = 1'b1;
        end else if (sample_edge) begin
          if (bit_cnt_q == CntW'(WIDTH - 1)) begin
            bit_cnt_d    = '0;
            start_pend_d = 1'b1;
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            bit_cnt_d  = bit_cnt_q + 1'b1;
            rx_shift_d = rx_word;
          end
        // With cpha=0 the first bit is already on miso, so skip the shift edge trailing a word
        end else if (shift_edge && (mode_bits[0] || bit_cnt_q != '0)) begin
          miso_d     = first_bit(tx_shift_q, lsb_q);
          tx_shift_d = shift_out(tx_shift_q, lsb_q);
        end
      end
      default: state_d = StIdle;
    endcase

    if (word_start) begin
      if (tx_full_q) begin
        load_word = tx_hold_q;
        tx_full_d = 1'b0;
      end else if (tx_fill) begin
        load_word = tx_data;
        tx_full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
      mode_now_bits = mode_now;
      if (!mode_now_bits[0]) begin
        miso_d     = first_bit(load_word, lsb_now);
        tx_shift_d = shift_out(load_word, lsb_now);
      end else begin
        tx_shift_d = load_word;
      end
    end else begin
      mode_now_bits = mode_now;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= Mode0;
      lsb_q        <= 1'b0;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      rx_data_q    <= '0;
      tx_hold_q    <= '0;
      miso_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      tx_full_q    <= 1'b0;
      start_pend_q <= 1'b0;
      underrun_q   <= 1'b0;
      overrun_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      lsb_q        <= lsb_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      rx_data_q    <= rx_data_d;
      tx_hold_q    <= tx_hold_d;
      miso_q       <= miso_d;
      rx_valid_q   <= rx_valid_d;
      tx_full_q    <= tx_full_d;
      start_pend_q <= start_pend_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
      abort_q      <= abort_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = (state_q == StActive);
  assign busy        = (state_q == StActive);
  assign tx_ready    = ~tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;
  assign frame_abort = abort_q;

endmodule
